// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Turns host command frames, received as bytes from a UART/SPI link, into
//   single read or write transactions on the register-file bus. It sends back
//   one ack byte after a write and four data bytes after a read.
//
//   Frame layout: OP, ADDR_H, ADDR_L, then D3 D2 D1 D0 (writes only, MSB
//   first). With CMD_CHECKSUM_EN defined, a trailing CHK byte follows. CHK is
//   the XOR of every earlier byte in the frame.
//
//   Build option: `define CMD_CHECKSUM_EN turns on the trailing checksum byte.
//   Without it, a frame ends at ADDR_L (read) or D0 (write).
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous reset, active-high
//   rx_data_i   command byte in
//   rx_valid_i  rx_data_i is valid
//   rx_ready_o  a byte is taken when rx_valid_i & rx_ready_o
//   tx_data_o   response byte out
//   tx_valid_o  tx_data_o is valid; held stable until tx_ready_i
//   tx_ready_i  downstream accepts the byte
//   wr_en_o     one-cycle register write strobe
//   be_o        write byte enables
//   wr_addr_o   write address
//   wdata_o     write data
//   rd_en_o     one-cycle register read strobe
//   rd_addr_o   read address
//   rdata_i     read data, valid while rd_rdy_i
//   rd_rdy_i    read data valid strobe
module reg_bus_master #(
  parameter int RD_TO   = 16,
  parameter int IDLE_TO = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        wr_en_o,
  output logic [3:0]  be_o,
  output logic [15:0] wr_addr_o,
  output logic [31:0] wdata_o,
  output logic        rd_en_o,
  output logic [15:0] rd_addr_o,
  input  logic [31:0] rdata_i,
  input  logic        rd_rdy_i
);

  localparam int IdleW = $clog2(IDLE_TO + 1);
  localparam int RdW   = $clog2(RD_TO + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK,
    S_ISSUE_WR, S_ISSUE_RD, S_WAIT_RD, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        isWrite_q, isWrite_d;
  logic [3:0]  frameBe_q, frameBe_d;
  logic [15:0] frameAddr_q, frameAddr_d;
  logic [31:0] frameData_q, frameData_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [IdleW-1:0] idleCnt_q, idleCnt_d;
  logic [RdW-1:0]   rdCnt_q, rdCnt_d;
  logic [31:0] resp_q, resp_d;
  logic [1:0]  respLeft_q, respLeft_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] wrAddr_q, wrAddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] rdAddr_q, rdAddr_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  chkSum_q, chkSum_d;
`endif

  logic accept;
  logic frameDone;
  logic issueWr;
  logic issueRd;
  logic parsing;

  // Byte intake is open only while a frame is being collected. It is closed
  // during the bus transaction and the response.
  assign parsing    = (state_q == S_IDLE) || (state_q == S_ADDR_H) ||
                      (state_q == S_ADDR_L) || (state_q == S_DATA) ||
                      (state_q == S_CHK);
  assign rx_ready_o = parsing;
  assign accept     = rx_valid_i & rx_ready_o;

  // Strobes decode straight from the issue states, so each strobe lasts
  // exactly one cycle. Response bytes come from the top of a shift register.
  assign wr_en_o    = (state_q == S_ISSUE_WR);
  assign rd_en_o    = (state_q == S_ISSUE_RD);
  assign tx_valid_o = (state_q == S_RESP);
  assign tx_data_o  = tx_valid_o ? resp_q[31:24] : 8'h00;
  assign be_o       = be_q;
  assign wr_addr_o  = wrAddr_q;
  assign wdata_o    = wdata_q;
  assign rd_addr_o  = rdAddr_q;

  // State and datapath registers. Reset aborts any frame or response in
  // progress and clears the bus-facing registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      isWrite_q   <= 1'b0;
      frameBe_q   <= '0;
      frameAddr_q <= '0;
      frameData_q <= '0;
      byteCnt_q   <= '0;
      idleCnt_q   <= '0;
      rdCnt_q     <= '0;
      resp_q      <= '0;
      respLeft_q  <= '0;
      be_q        <= '0;
      wrAddr_q    <= '0;
      wdata_q     <= '0;
      rdAddr_q    <= '0;
`ifdef CMD_CHECKSUM_EN
      chkSum_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      isWrite_q   <= isWrite_d;
      frameBe_q   <= frameBe_d;
      frameAddr_q <= frameAddr_d;
      frameData_q <= frameData_d;
      byteCnt_q   <= byteCnt_d;
      idleCnt_q   <= idleCnt_d;
      rdCnt_q     <= rdCnt_d;
      resp_q      <= resp_d;
      respLeft_q  <= respLeft_d;
      be_q        <= be_d;
      wrAddr_q    <= wrAddr_d;
      wdata_q     <= wdata_d;
      rdAddr_q    <= rdAddr_d;
`ifdef CMD_CHECKSUM_EN
      chkSum_q    <= chkSum_d;
`endif
    end
  end

  // Next-state logic. The frame parser fills the frame registers. Once the
  // last byte is in, the bus-facing registers load in the same cycle, so
  // address, data and enables are already valid when the strobe rises.
  always_comb begin
    state_d     = state_q;
    isWrite_d   = isWrite_q;
    frameBe_d   = frameBe_q;
    frameAddr_d = frameAddr_q;
    frameData_d = frameData_q;
    byteCnt_d   = byteCnt_q;
    idleCnt_d   = '0;
    rdCnt_d     = rdCnt_q;
    resp_d      = resp_q;
    respLeft_d  = respLeft_q;
    be_d        = be_q;
    wrAddr_d    = wrAddr_q;
    wdata_d     = wdata_q;
    rdAddr_d    = rdAddr_q;
    frameDone   = 1'b0;
    issueWr     = 1'b0;
    issueRd     = 1'b0;
`ifdef CMD_CHECKSUM_EN
    chkSum_d    = chkSum_q;
    if (accept) chkSum_d = (state_q == S_IDLE) ? rx_data_i : (chkSum_q ^ rx_data_i);
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (rx_data_i[7:6])
            2'b10: begin
              isWrite_d = 1'b1;
              frameBe_d = rx_data_i[3:0];
              state_d   = S_ADDR_H;
            end
            2'b01: begin
              isWrite_d = 1'b0;
              state_d   = S_ADDR_H;
            end
            default: begin
              resp_d     = {8'hEE, 24'h0};
              respLeft_d = 2'd0;
              state_d    = S_RESP;
            end
          endcase
        end
      end
      S_ADDR_H: begin
        if (accept) begin
          frameAddr_d[15:8] = rx_data_i;
          state_d           = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (accept) begin
          frameAddr_d[7:0] = rx_data_i;
          if (isWrite_q) begin
            byteCnt_d = 2'd0;
            state_d   = S_DATA;
          end else begin
            frameDone = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          frameData_d = {frameData_q[23:0], rx_data_i};
          byteCnt_d   = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) frameDone = 1'b1;
        end
      end
`ifdef CMD_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (rx_data_i == chkSum_q) begin
            issueWr = isWrite_q;
            issueRd = !isWrite_q;
          end else begin
            resp_d     = {8'hEE, 24'h0};
            respLeft_d = 2'd0;
            state_d    = S_RESP;
          end
        end
      end
`endif
      S_ISSUE_WR: begin
        resp_d     = {8'hA5, 24'h0};
        respLeft_d = 2'd0;
        state_d    = S_RESP;
      end
      S_ISSUE_RD: begin
        rdCnt_d = '0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        // Only the first rd_rdy after the strobe counts. Once the wait
        // expires, a late rd_rdy lands in RESP or IDLE and is ignored.
        if (rd_rdy_i) begin
          resp_d     = rdata_i;
          respLeft_d = 2'd3;
          state_d    = S_RESP;
        end else if (rdCnt_q == RdW'(RD_TO - 1)) begin
          resp_d     = 32'hDEADBEEF;
          respLeft_d = 2'd3;
          state_d    = S_RESP;
        end else begin
          rdCnt_d = rdCnt_q + RdW'(1);
        end
      end
      S_RESP: begin
        if (tx_ready_i) begin
          if (respLeft_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            resp_d     = {resp_q[23:0], 8'h00};
            respLeft_d = respLeft_q - 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CMD_CHECKSUM_EN
    if (frameDone) state_d = S_CHK;
`else
    if (frameDone) begin
      issueWr = isWrite_q;
      issueRd = !isWrite_q;
    end
`endif

    if (issueWr) begin
      state_d  = S_ISSUE_WR;
      be_d     = frameBe_q;
      wrAddr_d = frameAddr_d;
      wdata_d  = frameData_d;
    end
    if (issueRd) begin
      state_d  = S_ISSUE_RD;
      rdAddr_d = frameAddr_d;
    end

    // Inter-byte timeout. It runs only while a frame is partially collected.
    // A stalled host therefore cannot wedge the parser mid-frame.
    if (parsing && state_q != S_IDLE && !accept) begin
      if (idleCnt_q == IdleW'(IDLE_TO - 1)) begin
        state_d = S_IDLE;
      end else begin
        idleCnt_d = idleCnt_q + IdleW'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master
//   Drives random command frames into reg_bus_master and emulates the
//   register file's read handshake. Expected bus transactions and response
//   bytes are queued when each frame is issued. A monitor pops them as the DUT
//   produces strobes and tx bytes, and it also checks strobe and response
//   latency.
module tb_reg_bus_master;

  localparam int RD_TO   = 16;
  localparam int IDLE_TO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        wrEn;
  logic [3:0]  be;
  logic [15:0] wrAddr;
  logic [31:0] wdata;
  logic        rdEn;
  logic [15:0] rdAddr;
  logic [31:0] rdata;
  logic        rdRdy;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          delay;
    logic [31:0] data;
  } rdplan_t;

  logic [7:0]  expTx[$];
  wr_t         expWr[$];
  logic [15:0] expRd[$];
  rdplan_t     plan[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;
  int txMode = 1;

  reg_bus_master #(.RD_TO(RD_TO), .IDLE_TO(IDLE_TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rxData), .rx_valid_i(rxValid), .rx_ready_o(rxReady),
    .tx_data_o(txData), .tx_valid_o(txValid), .tx_ready_i(txReady),
    .wr_en_o(wrEn), .be_o(be), .wr_addr_o(wrAddr), .wdata_o(wdata),
    .rd_en_o(rdEn), .rd_addr_o(rdAddr), .rdata_i(rdata), .rd_rdy_i(rdRdy)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Downstream acceptance. Mode 0 is random, mode 1 is always ready, and
  // mode 2 accepts one cycle in three.
  initial begin
    txReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (txMode)
        0:       txReady = ($urandom_range(0, 3) != 0);
        2:       txReady = ((cyc % 3) == 0);
        default: txReady = 1'b1;
      endcase
    end
  end

  // Register-file model for reads. Each rd_en takes the next planned
  // response: rd_rdy pulses `delay` cycles after the strobe, and rdata
  // carries junk at all other times.
  initial begin
    rdRdy = 1'b0;
    rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && rdEn && plan.size() > 0) begin
        rdplan_t p;
        p = plan.pop_front();
        repeat (p.delay) @(posedge clk);
        #1;
        rdRdy = 1'b1;
        rdata = p.data;
        @(posedge clk);
        #1;
        rdRdy = 1'b0;
        rdata = $urandom;
      end
    end
  end

  // Monitor and scoreboard. Everything is sampled on the falling edge.
  int   rdEnCyc = 0;
  bit   waitRd = 0;
  int   expFirst = -1;
  bit   stallPend = 0;
  logic [7:0] stallData = 8'h0;
  bit   prevValid = 0;

  always @(negedge clk) begin
    if (rst) begin
      waitRd = 0;
      expFirst = -1;
      stallPend = 0;
      prevValid = 0;
    end else begin
      if (wrEn && rdEn) checkOutput("strobe_exclusive", {30'h0, wrEn, rdEn}, 32'h2);
      if (wrEn) begin
        if (expWr.size() == 0) checkOutput("wr_unexpected", {16'h0, wrAddr}, 32'hFFFFFFFF);
        else begin
          wr_t w;
          w = expWr.pop_front();
          checkOutput("wr_addr", {16'h0, wrAddr}, {16'h0, w.addr});
          checkOutput("wr_be", {28'h0, be}, {28'h0, w.be});
          checkOutput("wr_data", wdata, w.data);
        end
        checkOutput("wr_latency", cyc, lastAcceptCyc + 1);
        expFirst = cyc + 1;
      end
      if (rdEn) begin
        if (expRd.size() == 0) checkOutput("rd_unexpected", {16'h0, rdAddr}, 32'hFFFFFFFF);
        else checkOutput("rd_addr", {16'h0, rdAddr}, {16'h0, expRd.pop_front()});
        checkOutput("rd_latency", cyc, lastAcceptCyc + 1);
        rdEnCyc = cyc;
        waitRd = 1;
      end else if (waitRd) begin
        if (rdRdy) begin
          expFirst = cyc + 1;
          waitRd = 0;
        end else if (cyc == rdEnCyc + RD_TO) begin
          expFirst = cyc + 1;
          waitRd = 0;
        end
      end
      if (stallPend) checkOutput("tx_hold", {23'h0, txValid, txData}, {24'h1, stallData});
      if (txValid && !prevValid && expFirst >= 0) begin
        checkOutput("resp_latency", cyc, expFirst);
        expFirst = -1;
      end
      if (txValid && txReady) begin
        if (expTx.size() == 0) checkOutput("tx_unexpected", {24'h0, txData}, 32'hFFFFFFFF);
        else checkOutput("tx_byte", {24'h0, txData}, {24'h0, expTx.pop_front()});
      end
      stallPend = txValid && !txReady;
      stallData = txData;
      prevValid = txValid;
    end
  end

  // Offers one byte and holds it until accepted, with a bounded wait.
  task automatic sendByte(input logic [7:0] b);
    bit done = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    rxValid = 1'b1;
    rxData  = b;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (rxReady) begin
        lastAcceptCyc = cyc;
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    rxValid = 1'b0;
    if (!done) checkOutput("rx_accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic sendFrame(input logic [7:0] op, input logic [15:0] addr,
                           input logic [31:0] data, input bit isWr, input bit badChk);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    bytes.push_back(op);
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    if (isWr) for (int i = 3; i >= 0; i--) bytes.push_back(data[i*8 +: 8]);
    chk = 8'h00;
    foreach (bytes[i]) chk ^= bytes[i];
`ifdef CMD_CHECKSUM_EN
    bytes.push_back(badChk ? ~chk : chk);
`endif
    foreach (bytes[i]) sendByte(bytes[i]);
  endtask

  task automatic applyStimulusWrite(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.be   = op[3:0];
    w.data = data;
    expWr.push_back(w);
    expTx.push_back(8'hA5);
    sendFrame(op, addr, data, 1'b1, 1'b0);
  endtask

  task automatic applyStimulusRead(input logic [7:0] op, input logic [15:0] addr,
                                   input logic [31:0] data, input int delay);
    rdplan_t p;
    logic [31:0] resp;
    p.delay = delay;
    p.data  = data;
    plan.push_back(p);
    expRd.push_back(addr);
    resp = (delay < RD_TO) ? data : 32'hDEADBEEF;
    for (int i = 3; i >= 0; i--) expTx.push_back(resp[i*8 +: 8]);
    sendFrame(op, addr, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic applyStimulusBadOp(input logic [7:0] op);
    expTx.push_back(8'hEE);
    sendByte(op);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000; n++) begin
      if (expTx.size() == 0 && expWr.size() == 0 && expRd.size() == 0 && !txValid) break;
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, {31'h0, rxReady}, 32'h1);
    checkOutput({tag, "_strobes"}, {29'h0, txValid, wrEn, rdEn}, 32'h0);
    checkOutput({tag, "_tx_data"}, {24'h0, txData}, 32'h0);
    checkOutput({tag, "_wr_addr_be"}, {12'h0, be, wrAddr}, 32'h0);
    checkOutput({tag, "_wdata"}, wdata, 32'h0);
    checkOutput({tag, "_rd_addr"}, {16'h0, rdAddr}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    rxValid = 1'b0;
    rxData = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed frames: write, read, read under back-pressure, bad op.
    txMode = 1;
    applyStimulusWrite(8'h82, 16'h0004, 32'h12345678);
    applyStimulusRead(8'h40, 16'h0010, 32'hC0FFEE01, 1);
    drain();
    txMode = 2;
    applyStimulusRead(8'h40, 16'h0010, 32'hC0FFEE01, 1);
    drain();
    txMode = 1;
    applyStimulusBadOp(8'hC3);
`ifdef CMD_CHECKSUM_EN
    expTx.push_back(8'hEE);
    sendFrame(8'h82, 16'h0004, 32'h12345678, 1'b1, 1'b1);
`endif

    // Read timeout: the late rd_rdy must be ignored, and the next write
    // must still go through.
    applyStimulusRead(8'h40, 16'h0010, 32'h11111111, RD_TO + 3);
    applyStimulusWrite(8'h82, 16'h0004, 32'h12345678);
    drain();

    // Partial frame abandoned past the inter-byte timeout.
    sendByte(8'h82);
    sendByte(8'h00);
    repeat (IDLE_TO + 5) @(posedge clk);
    #1;
    applyStimulusRead(8'h40, 16'h0010, 32'hA5A5F00D, 3);
    drain();

    // Reset in the middle of the data bytes.
    sendByte(8'h82);
    sendByte(8'h00);
    sendByte(8'h04);
    sendByte(8'h12);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("midframe_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulusWrite(8'h82, 16'h0004, 32'h12345678);
    drain();

    // Random mix under random back-pressure.
    txMode = 0;
    for (int k = 0; k < 40; k++) begin
      int kind;
      logic [7:0] op;
      kind = $urandom_range(0, 9);
      if (kind <= 3 || kind == 9) begin
        op = {2'b10, 2'($urandom), 4'($urandom)};
        applyStimulusWrite(op, 16'($urandom), $urandom);
      end else if (kind <= 6) begin
        op = {2'b01, 6'($urandom)};
        applyStimulusRead(op, 16'($urandom), $urandom, $urandom_range(1, RD_TO - 1));
      end else if (kind == 7) begin
        op = {2'b01, 6'($urandom)};
        applyStimulusRead(op, 16'($urandom), $urandom, RD_TO + 3);
      end else begin
        op = {($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 6'($urandom)};
        applyStimulusBadOp(op);
      end
    end
    drain();

    checkOutput("tx_queue_drained", expTx.size(), 32'h0);
    checkOutput("wr_queue_drained", expWr.size(), 32'h0);
    checkOutput("rd_queue_drained", expRd.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
